expr_char_tx: RTL
=================

# expr_char_tx

Serializes an arithmetic expression of the form `d op d … = d op d …` into an ASCII character stream, one byte per handshake. It is the transmit-side counterpart of the expression-recognizer FSM. It feeds that checker, or any byte sink, from a loaded token set, and its output must always be accepted by the checker. It is used to generate well-formed stimulus streams and result strings inside the calculator datapath.

## Interface
Parameters:
- `MAX_TERMS`, 4: maximum single-digit terms per side (≥2).
- `CW`, `$clog2(MAX_TERMS+1)`: width of the term-count fields.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: load request; sampled only while idle.
- `lhs_cnt`, in, CW: number of left-hand terms, 1..MAX_TERMS.
- `lhs_dig`, in, 4*MAX_TERMS: BCD digits; term i is at `[4i+3:4i]`.
- `lhs_op`, in, 2*(MAX_TERMS-1): operator between term i and i+1 is at `[2i+1:2i]`.
- `rhs_cnt`, `rhs_dig`, `rhs_op`: same layout for the right-hand side.
- `tx_data`, out, 8: ASCII character.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: sink accepts the character.
- `tx_last`, out, 1: marks the final character of the expression.
- `busy`, out, 1: an expression is loaded or being emitted.
- `done`, out, 1: one-cycle pulse after the last character is accepted.
- `err`, out, 1: one-cycle pulse when a `start` is rejected.

## Operation
- Operator codes: 0 `+`, 1 `-`, 2 `*`, 3 `/`. Digit d encodes as 8'h30+d. `=` is 8'h3D; space is 8'h20.
- FSM states:
  - IDLE
  - LHS_DIG → LHS_OP (if more LHS terms remain) or EQ
  - LHS_OP → LHS_DIG
  - EQ → RHS_DIG
  - RHS_DIG → RHS_OP (if more RHS terms remain) or IDLE after the final handshake
  - RHS_OP → RHS_DIG
  - SPACE: only when configured.
- A state advances only on the handshake `tx_valid && tx_ready`.
- Character count L=lhs_cnt, R=rhs_cnt: 2L+2R-1 characters without spaces.
- Validation happens when `start` is seen in IDLE:
  - `lhs_cnt` or `rhs_cnt` outside 1..MAX_TERMS, or any used digit >9, rejects the load.
  - A rejected load pulses `err`, emits nothing, and leaves the block in IDLE.
  - Unused digits and operators are ignored.
- All inputs are captured into internal registers on an accepted `start`. Later input changes have no effect.
- `start` while busy is ignored, with no `err`.
- `tx_data` and `tx_last` must stay stable while `tx_valid && !tx_ready`.

## Timing
- Reset values: `tx_data`=8'h00, `tx_valid`=0, `tx_last`=0, `busy`=0, `done`=0, `err`=0, FSM in IDLE.
- Start sequence:
  - Accepted `start` at edge N.
  - At N+1: `busy`=1, `tx_valid`=1, `tx_data`=first digit.
- Throughput: one character per cycle while `tx_ready` stays high. Outputs are fully registered.
- End of stream:
  - Final handshake at edge M.
  - At M+1: `tx_valid`=0, `tx_last`=0, `busy`=0, `done`=1.
  - A `start` in cycle M+1 is accepted.
- `err` is asserted in the cycle after the rejected `start`.
- Reset mid-stream: the stream aborts immediately, with no `tx_last` and no `done`.

## Configuration
- `EXPR_TX_SPACE_EN` defined:
  - One space is inserted after every operator and after `=`, via the SPACE state.
  - Character count becomes 3L+3R-2.
  - Spaces never follow a digit and never lead the stream, since the checker rejects those positions.
- Undefined: no spaces are emitted and the SPACE state is absent.

## Structure
- `expr_pkg` holds:
  - the state enum;
  - operator code localparams;
  - ASCII constants (`CH_ZERO`, `CH_PLUS`, `CH_MINUS`, `CH_MUL`, `CH_DIV`, `CH_EQ`, `CH_SP`).
- The checker shares this package.
- One combinational sub-module, `expr_ascii_enc`: maps a (kind, digit/op) token to an ASCII byte.
- The FSM, term index counter and output register live in the top module.

## Test plan
- L=2 {3,4} op `+`, R=1 {7}, `tx_ready`=1 → `3`,`+`,`4`,`=`,`7` on consecutive cycles; `tx_last` on `7`; `done` one cycle later.
- Same load with `tx_ready` toggled 1,0,0,1,… → identical byte sequence; `tx_data` held stable during stalls.
- L=3 {9,0,5} ops `*`,`/`, R=2 {1,2} op `-` with `EXPR_TX_SPACE_EN` → `9* 0/ 5= 1- 2` (13 bytes); the checker FSM ends in its accepting state.
- `lhs_cnt`=0, or a digit 4'hA → `err` pulse, `tx_valid` stays 0, `busy` stays 0.
- Reset asserted on the 3rd character → all outputs 0 asynchronously; next `start` emits a fresh stream from its first digit.
- `start` pulsed mid-stream, then again in the `done` cycle → first pulse ignored, second accepted, back-to-back streams.

Source files
------------

// File: rtl/expr_pkg.sv
// expr_pkg: shared FSM states, operator codes and ASCII constants for the expression TX/checker pair
package expr_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_SP    = 8'h20;

    typedef enum logic [2:0] {
        IDLE, LHS_DIG, LHS_OP, EQ, RHS_DIG, RHS_OP
`ifdef EXPR_TX_SPACE_EN
        , SPACE
`endif
    } state_t;

    typedef enum logic [1:0] {TK_DIG, TK_OP, TK_EQ, TK_SP} tok_t;

endpackage

// File: rtl/expr_char_tx_if.sv
// expr_char_tx_if: load request and character stream handshake of the expression transmitter
interface expr_char_tx_if #(
    parameter int MAX_TERMS = 4,
    parameter int CW = $clog2(MAX_TERMS + 1)
) ();
    logic                       start;
    logic [CW-1:0]              lhs_cnt;
    logic [4*MAX_TERMS-1:0]     lhs_dig;
    logic [2*(MAX_TERMS-1)-1:0] lhs_op;
    logic [CW-1:0]              rhs_cnt;
    logic [4*MAX_TERMS-1:0]     rhs_dig;
    logic [2*(MAX_TERMS-1)-1:0] rhs_op;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready;
    logic                       tx_last;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport slave (
        input  start, lhs_cnt, lhs_dig, lhs_op, rhs_cnt, rhs_dig, rhs_op, tx_ready,
        output tx_data, tx_valid, tx_last, busy, done, err
    );

    modport master (
        output start, lhs_cnt, lhs_dig, lhs_op, rhs_cnt, rhs_dig, rhs_op, tx_ready,
        input  tx_data, tx_valid, tx_last, busy, done, err
    );
endinterface

// File: rtl/expr_ascii_enc.sv
// expr_ascii_enc: maps a (kind, digit/op) token to its ASCII byte
module expr_ascii_enc
    import expr_pkg::*;
(
    input  tok_t       kind_i,
    input  logic [3:0] val_i,
    output logic [7:0] char_o
);
    logic [7:0] op_ch;

    // operator code to symbol, then select by token kind
    always_comb begin
        op_ch  = val_i[1:0] == OP_ADD ? CH_PLUS :
                 val_i[1:0] == OP_SUB ? CH_MINUS :
                 val_i[1:0] == OP_MUL ? CH_MUL : CH_DIV;
        char_o = kind_i == TK_DIG ? CH_ZERO + {4'h0, val_i} :
                 kind_i == TK_OP  ? op_ch :
                 kind_i == TK_EQ  ? CH_EQ : CH_SP;
    end
endmodule

// File: rtl/expr_char_tx.sv
// expr_char_tx: serializes "d op d ... = d op d ..." to ASCII bytes; EXPR_TX_SPACE_EN adds a space after each operator and '='
module expr_char_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 4,
    parameter int CW = $clog2(MAX_TERMS + 1)
) (
    input logic           clk,
    input logic           reset,
    expr_char_tx_if.slave bus
);
`ifdef EXPR_TX_SPACE_EN
    localparam state_t L_OP_NEXT = SPACE;
    localparam state_t R_OP_NEXT = SPACE;
    localparam state_t EQ_NEXT   = SPACE;
    logic side_q, side_d;
`else
    localparam state_t L_OP_NEXT = LHS_DIG;
    localparam state_t R_OP_NEXT = RHS_DIG;
    localparam state_t EQ_NEXT   = RHS_DIG;
`endif

    state_t                     state_q, state_d;
    logic [CW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              lhs_cnt_q, rhs_cnt_q, lcnt, rcnt;
    logic [4*MAX_TERMS-1:0]     lhs_dig_q, rhs_dig_q, ldig, rdig;
    logic [2*(MAX_TERMS-1)-1:0] lhs_op_q, rhs_op_q, lop, rop;
    logic [7:0]                 tx_data_q, tx_data_d, enc_ch;
    logic                       tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic                       done_q, done_d, err_q, err_d;
    logic                       load_ok, accept, hs;
    tok_t                       kind;
    logic [3:0]                 val;

    // a load is legal when both counts are in range and every used digit is BCD
    always_comb begin
        load_ok = bus.lhs_cnt != '0 && bus.lhs_cnt <= CW'(MAX_TERMS) &&
                  bus.rhs_cnt != '0 && bus.rhs_cnt <= CW'(MAX_TERMS);
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (i < int'(bus.lhs_cnt) && bus.lhs_dig[4*i +: 4] > 4'd9) load_ok = 1'b0;
            if (i < int'(bus.rhs_cnt) && bus.rhs_dig[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    assign accept = state_q == IDLE && bus.start && load_ok;
    assign hs     = tx_valid_q && bus.tx_ready;

    // next state and next output byte; on a load the first byte comes straight from the inputs
    always_comb begin
        lcnt    = accept ? bus.lhs_cnt : lhs_cnt_q;
        rcnt    = accept ? bus.rhs_cnt : rhs_cnt_q;
        ldig    = accept ? bus.lhs_dig : lhs_dig_q;
        rdig    = accept ? bus.rhs_dig : rhs_dig_q;
        lop     = accept ? bus.lhs_op : lhs_op_q;
        rop     = accept ? bus.rhs_op : rhs_op_q;
        state_d = state_q;
        idx_d   = idx_q;
`ifdef EXPR_TX_SPACE_EN
        side_d  = accept ? 1'b0 : (hs && state_q == EQ) ? 1'b1 : side_q;
`endif
        if (accept) begin
            state_d = LHS_DIG;
            idx_d   = '0;
        end else if (hs) begin
            case (state_q)
                LHS_DIG: state_d = (idx_q + 1'b1) < lcnt ? LHS_OP : EQ;
                LHS_OP: begin
                    state_d = L_OP_NEXT;
                    idx_d   = idx_q + 1'b1;
                end
                EQ: begin
                    state_d = EQ_NEXT;
                    idx_d   = '0;
                end
                RHS_DIG: state_d = (idx_q + 1'b1) < rcnt ? RHS_OP : IDLE;
                RHS_OP: begin
                    state_d = R_OP_NEXT;
                    idx_d   = idx_q + 1'b1;
                end
`ifdef EXPR_TX_SPACE_EN
                SPACE: state_d = side_q ? RHS_DIG : LHS_DIG;
`endif
                default: ;
            endcase
        end
        kind = TK_DIG;
        val  = '0;
        case (state_d)
            LHS_DIG: val = ldig[4*idx_d +: 4];
            LHS_OP: begin
                kind = TK_OP;
                val  = {2'b00, lop[2*idx_d +: 2]};
            end
            EQ: kind = TK_EQ;
            RHS_DIG: val = rdig[4*idx_d +: 4];
            RHS_OP: begin
                kind = TK_OP;
                val  = {2'b00, rop[2*idx_d +: 2]};
            end
`ifdef EXPR_TX_SPACE_EN
            SPACE: kind = TK_SP;
`endif
            default: ;
        endcase
        tx_valid_d = state_d != IDLE;
        tx_data_d  = tx_valid_d ? enc_ch : 8'h00;
        tx_last_d  = state_d == RHS_DIG && (idx_d + 1'b1) == rcnt;
        done_d     = hs && state_q == RHS_DIG && state_d == IDLE;
        err_d      = state_q == IDLE && bus.start && !load_ok;
    end

    expr_ascii_enc u_enc (.kind_i(kind), .val_i(val), .char_o(enc_ch));

    // FSM, term index and registered outputs; reset aborts any stream at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef EXPR_TX_SPACE_EN
    // remembers which side the pending space belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) side_q <= 1'b0;
        else side_q <= side_d;
    end
`endif

    // token set snapshot taken on an accepted load
    always_ff @(posedge clk) begin
        if (accept) begin
            lhs_cnt_q <= bus.lhs_cnt;
            rhs_cnt_q <= bus.rhs_cnt;
            lhs_dig_q <= bus.lhs_dig;
            rhs_dig_q <= bus.rhs_dig;
            lhs_op_q  <= bus.lhs_op;
            rhs_op_q  <= bus.rhs_op;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_last  = tx_last_q;
    assign bus.busy     = tx_valid_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
